// File: rtl/regfile_pkg.sv
// Shared constants for the multi-port register file: default geometry,
// the hardwired-zero address and debug register indices used when probing.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;
  localparam int unsigned DEF_NREAD = 2;
  localparam int unsigned ZERO_ADDR = 0;

  typedef enum int unsigned {
    RESULT = 3,
    A0     = 4,
    DONE   = 9,
    SP     = 29,
    RA     = 31
  } debug_reg_e;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, pending lookup and the optional
// same-cycle write bypass (enabled by defining REGFILE_BYPASS_EN).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic [AW-1:0]                addr,
  input  logic [DEPTH-1:0][WIDTH-1:0]  regs,
  input  logic [DEPTH-1:0]             pending,
  input  logic                         write_valid,
  input  logic [AW-1:0]                write_addr,
  input  logic [WIDTH-1:0]             write_data,
  input  logic                         reserve_valid,
  input  logic [AW-1:0]                reserve_addr,
  output logic [WIDTH-1:0]             data,
  output logic                         pend
);

  logic is_zero;

  assign is_zero = (ZERO_REG != 0) && (addr == AW'(ZERO_ADDR));

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    data = regs[addr];
    pend = pending[addr];
    // A write in flight resolves the hazard unless a new producer claims the same register
    if (write_valid && (write_addr == addr)) begin
      data = write_data;
      pend = reserve_valid && (reserve_addr == addr);
    end
    if (is_zero) begin
      data = '0;
      pend = 1'b0;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{write_valid, write_addr, write_data, reserve_valid, reserve_addr};

  always_comb begin
    data = regs[addr];
    pend = pending[addr];
    if (is_zero) begin
      data = '0;
      pend = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/regfile_multiport.sv
// DEPTH x WIDTH register file with one write port, NREAD read ports and
// per-register pending bits. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned NREAD    = DEF_NREAD,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   RegWrite,
  input  logic [AW-1:0]          WriteRegister,
  input  logic [WIDTH-1:0]       WriteData,
  input  logic                   Reserve,
  input  logic [AW-1:0]          ReserveRegister,
  input  logic [NREAD*AW-1:0]    ReadRegister,
  output logic [NREAD*WIDTH-1:0] ReadData,
  output logic [NREAD-1:0]       ReadPending,
  output logic [AW:0]            PendingCount
);

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            pending;
  logic [AW:0]                 count;
  logic                        write_valid;
  logic                        reserve_valid;
  logic                        pending_inc;
  logic                        pending_dec;

  always_comb begin
    write_valid   = RegWrite && !((ZERO_REG != 0) && (WriteRegister == AW'(ZERO_ADDR)));
    reserve_valid = Reserve && !((ZERO_REG != 0) && (ReserveRegister == AW'(ZERO_ADDR)));
    // Count tracks the pending vector by delta; a same-address reserve cancels the write's clear
    pending_inc   = reserve_valid && !pending[ReserveRegister];
    pending_dec   = write_valid && pending[WriteRegister]
                    && !(reserve_valid && (ReserveRegister == WriteRegister));
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      regs <= '0;
    end else if (write_valid) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pending <= '0;
    end else begin
      if (write_valid)   pending[WriteRegister]   <= 1'b0;
      if (reserve_valid) pending[ReserveRegister] <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      count <= '0;
    end else if (pending_inc && !pending_dec) begin
      count <= count + {{AW{1'b0}}, 1'b1};
    end else if (pending_dec && !pending_inc) begin
      count <= count - {{AW{1'b0}}, 1'b1};
    end
  end

  assign PendingCount = count;

  for (genvar k = 0; k < NREAD; k++) begin : g_read
    regfile_read_port #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .addr          (ReadRegister[k*AW +: AW]),
      .regs          (regs),
      .pending       (pending),
      .write_valid   (write_valid),
      .write_addr    (WriteRegister),
      .write_data    (WriteData),
      .reserve_valid (reserve_valid),
      .reserve_addr  (ReserveRegister),
      .data          (ReadData[k*WIDTH +: WIDTH]),
      .pend          (ReadPending[k])
    );
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default instance plus a
// WIDTH=16/DEPTH=8/NREAD=3/ZERO_REG=0 instance; honours REGFILE_BYPASS_EN.
module tb_regfile_multiport;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  logic        reg_write, reserve;
  logic [4:0]  wr_addr, rsv_addr;
  logic [31:0] wr_data;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [5:0]  pcount;

  logic        s_reg_write, s_reserve;
  logic [2:0]  s_wr_addr, s_rsv_addr;
  logic [15:0] s_wr_data;
  logic [8:0]  s_rd_addr;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_pend;
  logic [3:0]  s_pcount;

  regfile_multiport dut (
    .Clk(Clk), .Rst_n(Rst_n), .RegWrite(reg_write), .WriteRegister(wr_addr),
    .WriteData(wr_data), .Reserve(reserve), .ReserveRegister(rsv_addr),
    .ReadRegister(rd_addr), .ReadData(rd_data), .ReadPending(rd_pend),
    .PendingCount(pcount)
  );

  regfile_multiport #(.WIDTH(16), .DEPTH(8), .NREAD(3), .ZERO_REG(0)) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .RegWrite(s_reg_write), .WriteRegister(s_wr_addr),
    .WriteData(s_wr_data), .Reserve(s_reserve), .ReserveRegister(s_rsv_addr),
    .ReadRegister(s_rd_addr), .ReadData(s_rd_data), .ReadPending(s_rd_pend),
    .PendingCount(s_pcount)
  );

  typedef struct {
    string       name;
    bit          swp;
    int          port;
    logic [31:0] data;
    bit          pend;
    int          cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic expect_rd(input string name, input bit swp, input int port,
                           input logic [31:0] data, input bit pend, input int cnt);
    exp_t e;
    e.name = name; e.swp = swp; e.port = port;
    e.data = data; e.pend = pend; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", name, what, act, exp);
  endtask

  // Monitor: outputs are combinational, so every queued expectation is due at the next negedge
  always @(negedge Clk) begin
    while (sb.size() != 0) begin
      exp_t        e;
      logic [31:0] ad;
      logic [31:0] ap;
      logic [31:0] ac;
      e = sb.pop_front();
      if (e.swp) begin
        ad = 32'(s_rd_data[e.port*16 +: 16]);
        ap = 32'(s_rd_pend[e.port]);
        ac = 32'(s_pcount);
      end else begin
        ad = rd_data[e.port*32 +: 32];
        ap = 32'(rd_pend[e.port]);
        ac = 32'(pcount);
      end
      cmp(e.name, "data", ad, e.data);
      cmp(e.name, "pending", ap, 32'(e.pend));
      cmp(e.name, "count", ac, 32'(e.cnt));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_srd(input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    s_rd_addr = {a2, a1, a0};
  endtask

  initial begin
    reg_write = 0; reserve = 0; wr_addr = 0; rsv_addr = 0; wr_data = 0; rd_addr = 0;
    s_reg_write = 0; s_reserve = 0; s_wr_addr = 0; s_rsv_addr = 0; s_wr_data = 0; s_rd_addr = 0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    set_rd(5'd0, 5'd5);
    expect_rd("reset_r0", 0, 0, 32'h0, 0, 0);
    expect_rd("reset_r5", 0, 1, 32'h0, 0, 0);

    // write r7, read on both ports; r0 writes dropped
    tick; reg_write = 1; wr_addr = 5'd7; wr_data = 32'h12345678; set_rd(5'd7, 5'd7);
    expect_rd("t2_same_cycle", 0, 0, BYP ? 32'h12345678 : 32'h0, 0, 0);
    tick; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; set_rd(5'd7, 5'd0);
    expect_rd("t2_r7_p0", 0, 0, 32'h12345678, 0, 0);
    expect_rd("t2_r0_during_write", 0, 1, 32'h0, 0, 0);
    tick; reg_write = 0; set_rd(5'd0, 5'd7);
    expect_rd("t2_r0_dropped", 0, 0, 32'h0, 0, 0);
    expect_rd("t2_r7_p1", 0, 1, 32'h12345678, 0, 0);

    // reserve r3, then write clears it
    tick; reserve = 1; rsv_addr = 5'(RESULT); set_rd(5'd3, 5'd0);
    expect_rd("t3_before_edge", 0, 0, 32'h0, 0, 0);
    tick; reserve = 0; reg_write = 1; wr_addr = 5'd3; wr_data = 32'hA5;
    expect_rd("t3_reserved", 0, 0, BYP ? 32'hA5 : 32'h0, !BYP, 1);
    tick; reg_write = 0;
    expect_rd("t3_written", 0, 0, 32'hA5, 0, 0);

    // same-edge write and reserve of r3
    tick; reg_write = 1; wr_addr = 5'd3; wr_data = 32'h1; reserve = 1; rsv_addr = 5'd3;
    expect_rd("t4_same_cycle", 0, 0, BYP ? 32'h1 : 32'hA5, BYP, 0);
    tick; reg_write = 0; reserve = 0;
    expect_rd("t4_after", 0, 0, 32'h1, 1, 1);

    // reserve every nonzero register (r3 already pending), then r0
    for (int i = 1; i < 32; i++) begin
      tick; reserve = 1; rsv_addr = 5'(i);
    end
    tick; rsv_addr = 5'd0; set_rd(5'd0, 5'd31);
    expect_rd("t5_all_r0", 0, 0, 32'h0, 0, 31);
    expect_rd("t5_all_r31", 0, 1, 32'h0, 1, 31);
    tick; reserve = 0; set_rd(5'd0, 5'd3);
    expect_rd("t5_r0_never_pending", 0, 0, 32'h0, 0, 31);
    expect_rd("t5_r3_still_pending", 0, 1, 32'h1, 1, 31);

    // write to pending then to non-pending; write r31 while r0 reserve is dropped
    tick; reg_write = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(5'd5, 5'd3);
    tick;
    expect_rd("wr_pending_r5", 0, 0, 32'hDEADBEEF, 0, 30);
    tick; reg_write = 0;
    expect_rd("wr_nonpending_r5", 0, 0, 32'hDEADBEEF, 0, 30);
    tick; reg_write = 1; wr_addr = 5'd31; wr_data = 32'h31; reserve = 1; rsv_addr = 5'd0;
    tick; reg_write = 0; reserve = 0; set_rd(5'd5, 5'd31);
    expect_rd("wr_r31_clears", 0, 1, 32'h31, 0, 29);
    expect_rd("pre_reset_r5", 0, 0, 32'hDEADBEEF, 0, 29);

    // async reset mid-cycle, then hold while low
    tick; #1 Rst_n = 1'b0;
    expect_rd("t1_async_r5", 0, 0, 32'h0, 0, 0);
    expect_rd("t1_async_r31", 0, 1, 32'h0, 0, 0);
    tick; reg_write = 1; wr_addr = 5'd5; wr_data = 32'h77; reserve = 1; rsv_addr = 5'd6;
    set_rd(5'd31, 5'd31);
    tick; reg_write = 0; reserve = 0; set_rd(5'd5, 5'd6);
    expect_rd("t1_hold_r5", 0, 0, 32'h0, 0, 0);
    expect_rd("t1_hold_r6", 0, 1, 32'h0, 0, 0);
    tick; Rst_n = 1'b1;

    // same-cycle bypass of r9
    tick; reg_write = 1; wr_addr = 5'(DONE); wr_data = 32'h55; set_rd(5'd9, 5'd0);
    expect_rd("t6_bypass_r9", 0, 0, BYP ? 32'h55 : 32'h0, 0, 0);
    tick; reg_write = 0;
    expect_rd("t6_after_r9", 0, 0, 32'h55, 0, 0);

    // swept instance: ordinary r0, three ports, 16-bit data
    tick; s_reg_write = 1; s_wr_addr = 3'd7; s_wr_data = 16'h5678; set_srd(3'd7, 3'd7, 3'd7);
    expect_rd("s_t2_same_cycle", 1, 0, BYP ? 32'h5678 : 32'h0, 0, 0);
    tick; s_wr_addr = 3'd0; s_wr_data = 16'hFFFF;
    expect_rd("s_t2_p0", 1, 0, 32'h5678, 0, 0);
    expect_rd("s_t2_p1", 1, 1, 32'h5678, 0, 0);
    expect_rd("s_t2_p2", 1, 2, 32'h5678, 0, 0);
    tick; s_reg_write = 0; set_srd(3'd7, 3'd0, 3'd7);
    expect_rd("s_t2_r0_ordinary", 1, 1, 32'hFFFF, 0, 0);
    tick; s_reserve = 1; s_rsv_addr = 3'd3; set_srd(3'd3, 3'd0, 3'd0);
    tick; s_reserve = 0; s_reg_write = 1; s_wr_addr = 3'd3; s_wr_data = 16'hA5;
    expect_rd("s_t3_reserved", 1, 0, BYP ? 32'hA5 : 32'h0, !BYP, 1);
    tick; s_reg_write = 0;
    expect_rd("s_t3_written", 1, 0, 32'hA5, 0, 0);
    tick; s_reg_write = 1; s_wr_addr = 3'd3; s_wr_data = 16'h1; s_reserve = 1; s_rsv_addr = 3'd3;
    tick; s_reg_write = 0; s_reserve = 0;
    expect_rd("s_t4_after", 1, 0, 32'h1, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick; s_reserve = 1; s_rsv_addr = 3'(i);
    end
    tick; s_reserve = 0; set_srd(3'd0, 3'd7, 3'd3);
    expect_rd("s_full_r0", 1, 0, 32'hFFFF, 1, 8);
    expect_rd("s_full_r7", 1, 1, 32'h5678, 1, 8);

    tick; tick;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
